// File: rtl/upgrade_spawner.sv
// Speed-upgrade producer: spawns a pickup at an LFSR-chosen position, keeps it visible for a
// bounded lifetime, and retires it on collection or timeout with a one-frame collector clear.
module upgrade_spawner #(
    parameter int          SPAWN_DELAY  = 300,
    parameter int          LIFETIME     = 600,
    parameter int          X_MIN        = 40,
    parameter int          X_MAX        = 600,
    parameter int          Y_MIN        = 40,
    parameter int          Y_MAX        = 440,
    parameter int          UPGRADE_SIZE = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       was_collected,
    output logic [9:0] UpgradeX,
    output logic [9:0] UpgradeY,
    output logic [9:0] Upgrade_Size,
    output logic       upgrade_visible,
    output logic       collector_clear,
    output logic [7:0] spawn_count
);

    localparam int CMAX = (SPAWN_DELAY > LIFETIME) ? SPAWN_DELAY : LIFETIME;
    localparam int CW   = ($clog2(CMAX) > 10) ? $clog2(CMAX) : 10;

    localparam logic [10:0] RX = 11'(X_MAX - X_MIN + 1);
    localparam logic [10:0] RY = 11'(Y_MAX - Y_MIN + 1);

    localparam logic [CW-1:0] DELAY_LAST = CW'(SPAWN_DELAY - 1);
    localparam logic [CW-1:0] LIFE_LAST  = CW'(LIFETIME - 1);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_CLEAR  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [15:0]   lfsr;
    logic [9:0]    off_x;
    logic [9:0]    off_y;

    // Ranges are at least 342, so a 10-bit value needs at most two subtractions.
    function automatic logic [9:0] fold(input logic [9:0] r, input logic [10:0] range);
        logic [10:0] v;
        v = {1'b0, r};
        if (v >= range) v = v - range;
        if (v >= range) v = v - range;
        return v[9:0];
    endfunction

    assign off_x        = fold(lfsr[9:0], RX);
    assign off_y        = fold(lfsr[15:6], RY);
    assign Upgrade_Size = 10'(UPGRADE_SIZE);

    // Free-running Galois LFSR, advances every frame regardless of game state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state           <= ST_WAIT;
            cnt             <= '0;
            UpgradeX        <= 10'(X_MIN);
            UpgradeY        <= 10'(Y_MIN);
            upgrade_visible <= 1'b0;
            collector_clear <= 1'b0;
            spawn_count     <= 8'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (enable) begin
                        if (cnt == DELAY_LAST) begin
                            state           <= ST_ACTIVE;
                            cnt             <= '0;
                            UpgradeX        <= 10'(X_MIN) + off_x;
                            UpgradeY        <= 10'(Y_MIN) + off_y;
                            upgrade_visible <= 1'b1;
                            if (spawn_count != 8'hFF)
                                spawn_count <= spawn_count + 8'd1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Collection is honoured even while paused and beats a same-frame timeout.
                    if (was_collected || (enable && cnt == LIFE_LAST)) begin
                        state           <= ST_CLEAR;
                        cnt             <= '0;
                        upgrade_visible <= 1'b0;
                        collector_clear <= 1'b1;
                    end else if (enable) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state           <= ST_WAIT;
                    cnt             <= '0;
                    collector_clear <= 1'b0;
                end
                default: begin
                    state           <= ST_WAIT;
                    cnt             <= '0;
                    upgrade_visible <= 1'b0;
                    collector_clear <= 1'b0;
                end
            endcase
        end
    end

endmodule
